dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width in bits; only 32 is supported.
REQ-002 Parameter DEPTH_LOG2, default 8: log2 of the number of words (256 words).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 RD  input  1  read request from the CPU MEM stage.
REQ-006 WR  input  1  write request from the CPU MEM stage.
REQ-007 A_DMEM  input  32  byte address.
REQ-008 D_out  input  32  write data from the CPU.
REQ-009 byte_mark  input  4  byte enables; bit i covers data bits [8i+7:8i].
REQ-010 DMEM_rst  input  1  memory-clear request; level sampled each cycle.
REQ-011 D_in  output  32  registered read data to the CPU.
REQ-012 busy  output  1  high while a clear sweep runs.
REQ-013 addr_err  output  1  one-cycle registered pulse flagging a rejected access.

Function
REQ-014 The word index SHALL be A_DMEM[DEPTH_LOG2+1:2].
REQ-015 An access SHALL be valid only when all of the following hold: A_DMEM[1:0]==0; A_DMEM[31:DEPTH_LOG2+2]==0; state is IDLE.
REQ-016 A valid WR SHALL update, at the sampling edge, only the bytes of the indexed word whose byte_mark bit is 1.
REQ-017 A WR with byte_mark==0 SHALL leave memory unchanged and SHALL NOT raise addr_err.
REQ-018 A valid RD SHALL load D_in with the indexed word at the sampling edge, giving one-cycle latency.
REQ-019 D_in SHALL hold its value in every cycle with no valid RD.
REQ-020 RD and WR asserted together to the same word SHALL be read-before-write: D_in gets the old word; the array gets the new bytes.
REQ-021 An invalid RD or WR in IDLE SHALL leave memory unchanged, load D_in with 0 on RD, and assert addr_err for the following cycle.
REQ-022 addr_err SHALL be 0 in every other cycle.
REQ-023 The FSM SHALL have two states, IDLE and CLEAR.
REQ-024 IDLE->CLEAR SHALL occur on an edge where DMEM_rst==1; the clear counter is set to 0 at that edge.
REQ-025 In CLEAR, each cycle SHALL write word[counter] to 0 and then increment the counter.
REQ-026 CLEAR->IDLE SHALL occur on the edge that writes word DEPTH-1, so the sweep takes exactly 2^DEPTH_LOG2 cycles.
REQ-027 DMEM_rst==1 while in CLEAR SHALL restart the counter at 0 and keep the state in CLEAR.
REQ-028 busy SHALL equal (state==CLEAR) and be registered.
REQ-029 In CLEAR, RD and WR SHALL be ignored: no memory update, D_in unchanged, no addr_err.
REQ-030 Counter width SHALL be DEPTH_LOG2 bits and SHALL wrap to 0 after DEPTH-1 without overflow logic.

Reset
REQ-031 On rst_n low, immediately and regardless of clk: state=IDLE, counter=0, D_in=32'h0, busy=0, addr_err=0.
REQ-032 Memory array contents SHALL NOT be reset by rst_n; software clears memory via DMEM_rst.
REQ-033 rst_n asserted during CLEAR SHALL abort the sweep; words already cleared stay 0 and the rest keep their prior contents.
REQ-034 The first valid access SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Clear then read: pulse DMEM_rst for 1 cycle -> busy high for exactly 256 cycles; then RD A=0x3FC -> D_in=0x00000000 one cycle later.
REQ-036 Byte write: WR A=0x10 D_out=0xAABBCCDD byte_mark=4'b1111, then WR A=0x10 D_out=0x11223344 byte_mark=4'b0101, then RD A=0x10 -> D_in=0xAA22CC44.
REQ-037 Simultaneous RD/WR: word 0x20 holds 0x12345678; RD+WR A=0x20 D_out=0xFFFFFFFF mask=1111 -> D_in=0x12345678; the next RD returns 0xFFFFFFFF.
REQ-038 Errors: RD A=0x402 -> addr_err=1 for 1 cycle, D_in=0; WR A=0x400 -> addr_err=1 and word 0 unchanged.
REQ-039 Clear restart: DMEM_rst at cycle 0 and again at cycle 100 -> busy stays high continuously and falls 256 cycles after the second pulse; WR during busy is ignored.
REQ-040 Async reset: rst_n low mid-sweep at counter=50 -> busy=0 and D_in=0 with no clock edge; word 49=0; word 60 keeps its prior value.

Source files
------------

// File: rtl/dmem_ctrl.sv
`timescale 1ns/1ps
// dmem_ctrl: word-addressed data memory with byte enables, address checking and a clear sweep
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   RD, WR          read / write requests from the CPU MEM stage
//   A_DMEM          byte address; only aligned, in-range addresses are accepted
//   D_out           write data from the CPU
//   byte_mark       byte enables, bit i covers data bits [8i+7:8i]
//   DMEM_rst        level-sampled request to zero the whole array
//   D_in            registered read data, one-cycle latency
//   busy            high while the clear sweep runs
//   addr_err        one-cycle pulse after a rejected access
module dmem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RD,
    input  logic                  WR,
    input  logic [31:0]           A_DMEM,
    input  logic [DATA_WIDTH-1:0] D_out,
    input  logic [3:0]            byte_mark,
    input  logic                  DMEM_rst,
    output logic [DATA_WIDTH-1:0] D_in,
    output logic                  busy,
    output logic                  addr_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   cnt;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   bmask;
    logic                    valid;
    logic                    wr_en;
    logic                    bad;

    always_comb begin
        idx   = A_DMEM[DEPTH_LOG2+1:2];
        valid = A_DMEM[1:0] == 2'b00 && A_DMEM[31:DEPTH_LOG2+2] == '0 && state == IDLE;
        bmask = {{8{byte_mark[3]}}, {8{byte_mark[2]}}, {8{byte_mark[1]}}, {8{byte_mark[0]}}};
        // an all-zero byte mask is a no-op write, never an error
        wr_en = WR && byte_mark != 4'b0000;
        bad   = state == IDLE && !valid && (RD || wr_en);
    end

    // array has no reset; read-before-write falls out of the registered D_in path
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (valid && wr_en)
            mem[idx] <= (mem[idx] & ~bmask) | (D_out & bmask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            D_in     <= '0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= bad;
            if (state == IDLE && RD)
                D_in <= valid ? mem[idx] : '0;
            if (DMEM_rst) begin
                state <= CLEAR;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule
